// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial sequence detector.
// Build option: SEQDET_MATCH_COUNT_EN adds the saturating match counter.
package seq_det_pkg;

  // Detector FSM: Idle = illegal config, Fill = collecting bits, Armed = able to match
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFill  = 2'd1,
    StArmed = 2'd2
  } seq_state_e;

  localparam int unsigned DefMaxLen  = 8;
  localparam int unsigned DefCntW    = 8;
  localparam logic [31:0] DefPattern = 32'b1101;
  localparam int unsigned DefLen     = 4;
  localparam bit          DefOverlap = 1'b1;

  // A pattern length is usable only when it is in 1..max_len
  function automatic logic len_is_legal(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_match_cnt.sv
// Saturating match counter for seq_detector_param.
// Only instantiated when SEQDET_MATCH_COUNT_EN is defined.
module seq_det_match_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // Clear on reset or reconfiguration, otherwise count up and stick at all-ones
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial sequence detector (1..MAX_LEN bit pattern,
// overlapping or non-overlapping). Emits a registered one-cycle dout pulse
// per match. Build option: SEQDET_MATCH_COUNT_EN adds a saturating match
// counter on match_count; without it match_count is tied to zero.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned         MAX_LEN     = DefMaxLen,
  parameter int unsigned         LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int unsigned         CNT_W       = DefCntW,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(DefPattern),
  parameter int unsigned         DEF_LEN     = DefLen,
  parameter bit                  DEF_OVERLAP = DefOverlap
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               dout,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic DefLegal = len_is_legal(DEF_LEN, MAX_LEN);

  seq_state_e         state_q, state_next;
  logic [MAX_LEN-1:0] history_q;
  logic [MAX_LEN-1:0] pattern_q;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   fill_q, fill_inc, fill_next;
  logic               overlap_q;
  logic               new_bit_q;
  logic               dout_q;
  logic               bit_valid;
  logic               match;

  // Mask off pattern/history bits at or above the active length
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < int'(MAX_LEN); i++) begin
      len_mask[i] = (i < int'(len_q));
    end
  end

  // Match on registered state; a bit is accepted only outside Idle and not under cfg_load
  always_comb begin
    bit_valid = din_valid && !cfg_load && (state_q != StIdle);
    match     = new_bit_q && (state_q == StArmed) &&
                (((history_q ^ pattern_q) & len_mask) == '0);
  end

  // Fill counter and Fill/Armed decision for the next cycle
  always_comb begin
    fill_inc  = (fill_q < len_q) ? fill_q + LEN_W'(1) : fill_q;
    fill_next = fill_q;
    if (match && !overlap_q) begin
      // Non-overlap: the next match needs len fresh bits, counting this one
      fill_next = bit_valid ? LEN_W'(1) : '0;
    end else if (bit_valid) begin
      fill_next = fill_inc;
    end
    state_next = (fill_next >= len_q) ? StArmed : StFill;
  end

  // Detector FSM, configuration latch, history shift register and output pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= DefLegal ? StFill : StIdle;
      pattern_q <= DEF_PATTERN;
      len_q     <= LEN_W'(DEF_LEN);
      overlap_q <= DEF_OVERLAP;
      history_q <= '0;
      fill_q    <= '0;
      new_bit_q <= 1'b0;
      dout_q    <= 1'b0;
    end else if (cfg_load) begin
      // Reconfiguration wins over any bit presented in the same cycle
      state_q   <= len_is_legal(32'(cfg_len), MAX_LEN) ? StFill : StIdle;
      pattern_q <= cfg_pattern;
      len_q     <= cfg_len;
      overlap_q <= cfg_overlap;
      history_q <= '0;
      fill_q    <= '0;
      new_bit_q <= 1'b0;
      dout_q    <= 1'b0;
    end else begin
      dout_q    <= match;
      new_bit_q <= bit_valid;
      if (bit_valid) begin
        history_q <= MAX_LEN'({history_q, din});
      end
      if (state_q != StIdle) begin
        fill_q  <= fill_next;
        state_q <= state_next;
      end
    end
  end

  assign dout    = dout_q;
  assign cfg_err = (state_q == StIdle);

`ifdef SEQDET_MATCH_COUNT_EN
  logic match_inc;
  assign match_inc = match && !cfg_load;

  seq_det_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cfg_load),
    .inc   (match_inc),
    .count (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param. A second instance with a
// 2-bit counter covers saturation. Expected counts follow SEQDET_MATCH_COUNT_EN.
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       dout, dout_sat;
  logic       cfg_err, cfg_err_sat;
  logic [7:0] match_count;
  logic [1:0] match_count_sat;

  int n_checks = 0;
  int n_errors = 0;

  seq_detector_param dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .dout        (dout),
    .cfg_err     (cfg_err),
    .match_count (match_count)
  );

  seq_detector_param #(
    .CNT_W (2)
  ) dut_sat (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .dout        (dout_sat),
    .cfg_err     (cfg_err_sat),
    .match_count (match_count_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cnt_exp(input int n);
    return CountEn ? n : 0;
  endfunction

  function automatic int sat_exp(input int n);
    return CountEn ? ((n > 3) ? 3 : n) : 0;
  endfunction

  // Vectors are written left to right in time order; exp is dout after each edge
  task automatic run_stream(input string tag, input int n, input logic [31:0] vld,
                            input logic [31:0] bits, input logic [31:0] exp);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_load  = 1'b0;
      din_valid = vld[i];
      din       = bits[i];
      @(posedge clk);
      #1;
      check($sformatf("%s dout c%0d", tag, n - i), 32'(dout), 32'(exp[i]));
      check($sformatf("%s dout_sat c%0d", tag, n - i), 32'(dout_sat), 32'(exp[i]));
    end
    din_valid = 1'b0;
  endtask

  task automatic load_cfg(input string tag, input logic [7:0] pat, input logic [3:0] len,
                          input logic ovl, input logic vld, input logic exp_err);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    din_valid   = vld;
    din         = 1'b1;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    din_valid = 1'b0;
    check({tag, " cfg_err"}, 32'(cfg_err), 32'(exp_err));
    check({tag, " dout"}, 32'(dout), 32'd0);
    check({tag, " count"}, 32'(match_count), 32'd0);
    check({tag, " count_sat"}, 32'(match_count_sat), 32'd0);
  endtask

  task automatic check_counts(input string tag, input int n);
    check({tag, " count"}, 32'(match_count), 32'(cnt_exp(n)));
    check({tag, " count_sat"}, 32'(match_count_sat), 32'(sat_exp(n)));
  endtask

  initial begin
    reset       = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = 8'h00;
    cfg_len     = 4'd0;
    cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset dout", 32'(dout), 32'd0);
    check("reset cfg_err", 32'(cfg_err), 32'd0);
    check_counts("reset", 0);

    // Defaults 1101 overlap: stream 1101101 -> pulses after bits 4 and 7
    run_stream("dflt", 9, 32'b111111100, 32'b110110100, 32'b000010010);
    check_counts("dflt", 2);

    // Non-overlap: same stream -> one pulse
    load_cfg("novl cfg", 8'h0D, 4'd4, 1'b0, 1'b0, 1'b0);
    run_stream("novl", 9, 32'b111111100, 32'b110110100, 32'b000010000);
    check_counts("novl", 1);

    // Illegal lengths: no detection at all
    load_cfg("len0 cfg", 8'hFF, 4'd0, 1'b1, 1'b0, 1'b1);
    run_stream("len0", 10, 32'h3FF, 32'h3FF, 32'h000);
    check("len0 cfg_err", 32'(cfg_err), 32'd1);
    load_cfg("len9 cfg", 8'hFF, 4'd9, 1'b1, 1'b0, 1'b1);
    run_stream("len9", 10, 32'h3FF, 32'h3FF, 32'h000);
    check("len9 cfg_err", 32'(cfg_err), 32'd1);
    check_counts("len9", 0);

    // Legal reload: single-bit pattern, overlap; back-to-back then gapped
    load_cfg("one cfg", 8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
    run_stream("one b2b", 5, 32'b11100, 32'b11100, 32'b01110);
    check_counts("one b2b", 3);
    run_stream("one gap", 7, 32'b1010100, 32'b1010100, 32'b0101010);
    check_counts("one gap", 6);

    // cfg_load after 3 of 4 bits with a valid bit in the same cycle
    load_cfg("drop cfg1", 8'h0D, 4'd4, 1'b1, 1'b0, 1'b0);
    run_stream("drop pre", 3, 32'b111, 32'b110, 32'b000);
    load_cfg("drop cfg2", 8'h0D, 4'd4, 1'b1, 1'b1, 1'b0);
    run_stream("drop post", 6, 32'b111100, 32'b110100, 32'b000010);
    check_counts("drop post", 1);

    // Full-width pattern
    load_cfg("len8 cfg", 8'b10110011, 4'd8, 1'b0, 1'b0, 1'b0);
    run_stream("len8", 9, 32'b111111110, 32'b101100110, 32'b000000001);
    check_counts("len8", 1);

    // Length 3 with ones above the active length in the pattern
    load_cfg("mask cfg", 8'b11111101, 4'd3, 1'b1, 1'b0, 1'b0);
    run_stream("mask", 6, 32'b111110, 32'b101010, 32'b000101);
    check_counts("mask", 2);

    // Reset mid-stream restores defaults and discards history
    run_stream("rst pre", 3, 32'b111, 32'b110, 32'b000);
    reset     = 1'b1;
    din_valid = 1'b1;
    din       = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    din_valid = 1'b0;
    check("rst dout", 32'(dout), 32'd0);
    check("rst cfg_err", 32'(cfg_err), 32'd0);
    check_counts("rst", 0);
    run_stream("rst post1", 3, 32'b100, 32'b100, 32'b000);
    run_stream("rst post2", 5, 32'b11100, 32'b10100, 32'b00010);
    check_counts("rst post2", 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
